// File: rtl/hilo_mac_unit_if.sv
// Request/response bundle for the HiLo multiply-accumulate unit.
// The requester drives the operation; the unit returns status and the committed HiLo halves.
interface hilo_mac_unit_if #(
   parameter int W    = 32,
   parameter int OP_W = 6
);
   logic            start;
   logic [OP_W-1:0] op;
   logic [W-1:0]    a;
   logic [W-1:0]    b;
   logic            busy;
   logic            done;
   logic            ovf;
   logic [W-1:0]    HiOut;
   logic [W-1:0]    LoOut;

   modport master (
      output start, op, a, b,
      input  busy, done, ovf, HiOut, LoOut
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, ovf, HiOut, LoOut
   );
endinterface

// File: rtl/hilo_mac_unit.sv
// MIPS-style HiLo unit: iterative shift-add unsigned multiply with multiply/add/sub
// commit into a 2W-bit HiLo register, plus direct MTHI/MTLO writes.
module hilo_mac_unit #(
   parameter int W    = 32,
   parameter int OP_W = 6
) (
   input logic              clk,
   input logic              rst,
   hilo_mac_unit_if.slave   bus
);

   localparam int CNT_W = $clog2(W + 1);

   localparam logic [OP_W-1:0] OP_MULTU = OP_W'(25);
   localparam logic [OP_W-1:0] OP_MADDU = OP_W'(1);
   localparam logic [OP_W-1:0] OP_MSUBU = OP_W'(5);
   localparam logic [OP_W-1:0] OP_MTHI  = OP_W'(17);
   localparam logic [OP_W-1:0] OP_MTLO  = OP_W'(19);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic             accept_mul;
   logic             write_hi;
   logic             write_lo;
   logic             last_step;

   logic [CNT_W-1:0] count;
   logic [2*W-1:0]   hilo;
   logic             ovf;
   logic             done;

   logic [OP_W-1:0]  op_p0;
   logic [2*W-1:0]   mcand_p0;
   logic [W-1:0]     mplier_p0;
   logic [2*W-1:0]   acc_p0;
   logic [2*W-1:0]   acc_nxt;

   // Returns {ovf_new, hilo_new}; MULTU clears the flag, MADDU/MSUBU make it sticky.
   function automatic logic [2*W:0] hilo_commit(
      input logic [OP_W-1:0] opc,
      input logic [2*W-1:0]  cur,
      input logic [2*W-1:0]  prod,
      input logic            ovf_in
   );
      logic [2*W:0] ext;
      logic [2*W:0] res;
      res = '0;
      ext = '0;
      case (opc)
         OP_MADDU: begin
            ext = {1'b0, cur} + {1'b0, prod};
            res = {ovf_in | ext[2*W], ext[2*W-1:0]};
         end
         OP_MSUBU: begin
            ext = {1'b0, cur} - {1'b0, prod};
            res = {ovf_in | ext[2*W], ext[2*W-1:0]};
         end
         default: res = {1'b0, prod};
      endcase
      return res;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      accept_mul = 1'b0;
      write_hi   = 1'b0;
      write_lo   = 1'b0;
      last_step  = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               case (bus.op)
                  OP_MULTU, OP_MADDU, OP_MSUBU: begin
                     accept_mul = 1'b1;
                     state_nxt  = S_MUL;
                  end
                  OP_MTHI: write_hi = 1'b1;
                  OP_MTLO: write_lo = 1'b1;
                  default: ;
               endcase
            end
         end
         S_MUL: begin
            if (count == CNT_W'(1)) begin
               last_step = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Operand latch and one shift-add step per cycle; the final step's sum feeds the commit directly.
   always_comb begin
      acc_nxt = acc_p0;
      if (mplier_p0[0]) begin
         acc_nxt = acc_p0 + mcand_p0;
      end
   end

   always_ff @(posedge clk) begin
      if (accept_mul) begin
         op_p0     <= bus.op;
         mcand_p0  <= {{W{1'b0}}, bus.a};
         mplier_p0 <= bus.b;
         acc_p0    <= '0;
      end else if (state == S_MUL) begin
         acc_p0    <= acc_nxt;
         mcand_p0  <= mcand_p0 << 1;
         mplier_p0 <= mplier_p0 >> 1;
      end
   end

   // Architectural state: only committed results ever reach hilo.
   always_ff @(posedge clk) begin
      if (rst) begin
         hilo  <= '0;
         ovf   <= 1'b0;
         done  <= 1'b0;
         count <= '0;
      end else begin
         done <= 1'b0;
         if (write_hi) begin
            hilo[2*W-1:W] <= bus.a;
            done          <= 1'b1;
         end
         if (write_lo) begin
            hilo[W-1:0] <= bus.a;
            done        <= 1'b1;
         end
         if (accept_mul) begin
            count <= CNT_W'(W);
         end else if (state == S_MUL) begin
            count <= count - CNT_W'(1);
         end
         if (last_step) begin
            {ovf, hilo} <= hilo_commit(op_p0, hilo, acc_nxt, ovf);
            done        <= 1'b1;
         end
      end
   end

   assign bus.busy  = (state == S_MUL);
   assign bus.done  = done;
   assign bus.ovf   = ovf;
   assign bus.HiOut = hilo[2*W-1:W];
   assign bus.LoOut = hilo[W-1:0];

endmodule

// File: tb/tb_hilo_mac_unit.sv
// Randomized bench for hilo_mac_unit against an operation-level arithmetic model of HiLo/ovf,
// with directed scenarios for back-to-back issue, ignored requests and reset abort.
module tb_hilo_mac_unit;

   localparam int W    = 32;
   localparam int OP_W = 6;

   localparam logic [OP_W-1:0] MULTU = 6'd25;
   localparam logic [OP_W-1:0] MADDU = 6'd1;
   localparam logic [OP_W-1:0] MSUBU = 6'd5;
   localparam logic [OP_W-1:0] MTHI  = 6'd17;
   localparam logic [OP_W-1:0] MTLO  = 6'd19;

   logic clk;
   logic rst;

   hilo_mac_unit_if #(.W(W), .OP_W(OP_W)) bus ();

   hilo_mac_unit #(.W(W), .OP_W(OP_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   logic [2*W-1:0] m_hilo;
   logic           m_ovf;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      bus.start = 1'b0;
      repeat (2) tick();
      rst    = 1'b0;
      m_hilo = '0;
      m_ovf  = 1'b0;
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_hi"},  64'(bus.HiOut), 64'(m_hilo[2*W-1:W]));
      chk({tag, "_lo"},  64'(bus.LoOut), 64'(m_hilo[W-1:0]));
      chk({tag, "_ovf"}, 64'(bus.ovf),   64'(m_ovf));
   endtask

   // Issue one request; returns in the cycle after the expected commit (the done cycle).
   task automatic run_op(input logic [OP_W-1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input int stray_at);
      int             c;
      logic           early_done;
      logic           moved;
      logic [2*W-1:0] held;
      logic [2*W-1:0] p;
      logic [2*W:0]   wide;
      bus.start = 1'b1;
      bus.op    = o;
      bus.a     = x;
      bus.b     = y;
      tick();
      bus.start = 1'b0;
      if (o == MULTU || o == MADDU || o == MSUBU) begin
         held       = {bus.HiOut, bus.LoOut};
         c          = 0;
         early_done = 1'b0;
         moved      = 1'b0;
         while (bus.busy && c < W + 4) begin
            if (c == stray_at) begin
               bus.start = 1'b1;
               bus.op    = MULTU;
               bus.a     = 7;
               bus.b     = 7;
            end
            tick();
            bus.start = 1'b0;
            c++;
            if (bus.busy) begin
               if (bus.done) early_done = 1'b1;
               if ({bus.HiOut, bus.LoOut} !== held) moved = 1'b1;
            end
         end
         chk("busy_cycles", 64'(c), 64'(W));
         chk("quiet_during_mul", {62'd0, early_done, moved}, 64'd0);
         p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
         case (o)
            MULTU: begin
               m_hilo = p;
               m_ovf  = 1'b0;
            end
            MADDU: begin
               wide   = {1'b0, m_hilo} + {1'b0, p};
               m_hilo = wide[2*W-1:0];
               if (wide[2*W]) m_ovf = 1'b1;
            end
            default: begin
               if (m_hilo < p) m_ovf = 1'b1;
               m_hilo = m_hilo - p;
            end
         endcase
      end else if (o == MTHI) begin
         m_hilo[2*W-1:W] = x;
      end else if (o == MTLO) begin
         m_hilo[W-1:0] = x;
      end else begin
         chk("ignored_done", 64'(bus.done), 64'd0);
         chk("ignored_busy", 64'(bus.busy), 64'd0);
         check_state("ignored");
         return;
      end
      chk("done", 64'(bus.done), 64'd1);
      chk("busy_after", 64'(bus.busy), 64'd0);
      check_state("commit");
   endtask

   initial begin
      int             r;
      int             dcount;
      logic [OP_W-1:0] o;
      logic [W-1:0]   x;
      logic [W-1:0]   y;
      logic           saw_done;

      rst       = 1'b1;
      bus.start = 1'b0;
      bus.op    = '0;
      bus.a     = '0;
      bus.b     = '0;
      do_reset();
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      check_state("rst");

      // Full-range multiply, then a MADDU issued in its done cycle.
      run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
      chk("ffxff_hi", 64'(bus.HiOut), 64'h0000_0000_FFFF_FFFE);
      chk("ffxff_lo", 64'(bus.LoOut), 64'h0000_0000_0000_0001);
      run_op(MADDU, 32'd2, 32'd3, -1);
      chk("madd_hi", 64'(bus.HiOut), 64'h0000_0000_FFFF_FFFE);
      chk("madd_lo", 64'(bus.LoOut), 64'h0000_0000_0000_0007);
      chk("madd_ovf", 64'(bus.ovf), 64'd0);
      tick();
      chk("done_one_cycle", 64'(bus.done), 64'd0);

      // Carry out of HiLo sets ovf; MULTU clears it.
      run_op(MTHI, 32'hFFFF_FFFF, 32'd0, -1);
      run_op(MTLO, 32'hFFFF_FFFF, 32'd0, -1);
      run_op(MADDU, 32'd1, 32'd1, -1);
      chk("wrap_hilo", {bus.HiOut, bus.LoOut}, 64'd0);
      chk("wrap_ovf", 64'(bus.ovf), 64'd1);
      run_op(MULTU, 32'd0, 32'd0, -1);
      chk("multu_clr_ovf", 64'(bus.ovf), 64'd0);

      // Borrow from zero.
      do_reset();
      run_op(MSUBU, 32'd1, 32'd1, -1);
      chk("borrow_hilo", {bus.HiOut, bus.LoOut}, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("borrow_ovf", 64'(bus.ovf), 64'd1);

      // A start while busy is dropped and yields no second done.
      run_op(MULTU, 32'd3, 32'd5, 9);
      chk("stray_lo", 64'(bus.LoOut), 64'd15);
      chk("stray_hi", 64'(bus.HiOut), 64'd0);
      dcount = 0;
      for (int i = 0; i < W + 4; i++) begin
         tick();
         if (bus.done) dcount++;
      end
      chk("single_done", 64'(dcount), 64'd0);

      // Reset mid-multiply aborts without commit or done.
      run_op(MTHI, 32'h1234_5678, 32'd0, -1);
      run_op(MTLO, 32'h1234_5678, 32'd0, -1);
      bus.start = 1'b1;
      bus.op    = MADDU;
      bus.a     = 32'd4;
      bus.b     = 32'd4;
      tick();
      bus.start = 1'b0;
      repeat (9) tick();
      chk("abort_busy_before", 64'(bus.busy), 64'd1);
      rst = 1'b1;
      tick();
      rst    = 1'b0;
      m_hilo = '0;
      m_ovf  = 1'b0;
      chk("abort_busy", 64'(bus.busy), 64'd0);
      chk("abort_done", 64'(bus.done), 64'd0);
      check_state("abort");
      saw_done = 1'b0;
      for (int i = 0; i < W + 2; i++) begin
         tick();
         if (bus.done) saw_done = 1'b1;
      end
      chk("abort_no_late_done", 64'(saw_done), 64'd0);
      run_op(6'd9, 32'hDEAD_BEEF, 32'h1, -1);

      // Random mix, issued back-to-back in each done cycle.
      for (int n = 0; n < 60; n++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1, 2: o = MULTU;
            3, 4:    o = MADDU;
            5, 6:    o = MSUBU;
            7:       o = MTHI;
            8:       o = MTLO;
            default: begin
               o = OP_W'($urandom_range(0, 63));
               if (o == MULTU || o == MADDU || o == MSUBU || o == MTHI || o == MTLO) o = 6'd0;
            end
         endcase
         x = $urandom();
         y = $urandom();
         if ($urandom_range(0, 3) == 0) x = ($urandom_range(0, 1) == 0) ? '0 : '1;
         if ($urandom_range(0, 3) == 0) y = ($urandom_range(0, 1) == 0) ? '0 : '1;
         run_op(o, x, y, -1);
      end
      tick();
      chk("final_done_low", 64'(bus.done), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/hilo_mac_unit.md
HILO_MAC_UNIT -- requirements
Module: hilo_mac_unit

Interface
REQ-001 Parameter W, default 32: operand width; HiLo accumulator is 2*W bits.
REQ-002 Parameter OP_W, default 6: opcode width.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 start  in  1  request strobe; sampled each rising edge.
REQ-006 op  in  OP_W  operation code, sampled with start.
REQ-007 a  in  W  multiplicand, or write data for MTHI/MTLO.
REQ-008 b  in  W  multiplier; ignored for MTHI/MTLO.
REQ-009 busy  out  1  high while a multiply operation is in progress.
REQ-010 done  out  1  one-cycle pulse when an operation commits.
REQ-011 ovf  out  1  sticky accumulate carry/borrow flag.
REQ-012 HiOut  out  W  committed HiLo[2W-1:W].
REQ-013 LoOut  out  W  committed HiLo[W-1:0].

Function
REQ-014 Opcodes: MULTU=25, MADDU=1, MSUBU=5, MTHI=17, MTLO=19; any other op with start SHALL be ignored with no state change and no done.
REQ-015 A request SHALL be accepted at an edge where start=1, busy=0 and rst=0; a, b and op SHALL be latched at that edge.
REQ-016 start while busy=1 SHALL be ignored; no queueing, latched operands unaffected.
REQ-017 MTHI/MTLO SHALL write a into Hi/Lo at the accept edge; busy stays 0; done=1 for the following cycle; ovf unchanged.
REQ-018 MULTU/MADDU/MSUBU SHALL use an iterative shift-add unsigned multiplier, one multiplier bit per cycle, with a step counter loaded to W at accept.
REQ-019 States: IDLE (busy=0), MUL (busy=1); IDLE->MUL on accepted multiply; MUL->IDLE at the edge the counter reaches its final step.
REQ-020 Latency: accept at edge 0; steps at edges 1..W; HiLo committed at edge W; after edge W busy=0 and done=1 for exactly one cycle.
REQ-021 A new request SHALL be acceptable at edge W+1 (the cycle in which done=1).
REQ-022 Commit: MULTU HiLo=P; MADDU HiLo=HiLo+P; MSUBU HiLo=HiLo-P; P is the full 2W-bit unsigned product; arithmetic is modulo 2^(2W).
REQ-023 MADDU carry-out or MSUBU borrow SHALL set ovf; MULTU commit clears ovf; otherwise ovf holds.
REQ-024 HiOut/LoOut SHALL show only committed values; they do not change during MUL.
REQ-025 MADDU/MSUBU SHALL use the HiLo value at the commit edge.

Reset
REQ-026 With rst=1 at an edge: HiLo=0, ovf=0, busy=0, done=0, counter=0, state=IDLE; rst has priority over start.
REQ-027 Reset during MUL SHALL abort the operation: no commit and no done pulse.

Verification
REQ-028 W=32, MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy 32 cycles, done 1 cycle, Hi=0xFFFFFFFE Lo=0x00000001, ovf=0.
REQ-029 MADDU a=2 b=3 issued in the done cycle -> Hi=0xFFFFFFFE Lo=0x00000007, ovf=0.
REQ-030 MTHI 0xFFFFFFFF, MTLO 0xFFFFFFFF, then MADDU 1*1 -> Hi=0 Lo=0, ovf=1; MULTU 0*0 then clears ovf.
REQ-031 From reset, MSUBU a=1 b=1 -> Hi=0xFFFFFFFF Lo=0xFFFFFFFF, ovf=1.
REQ-032 MULTU 3*5, start with op=MULTU a=7 b=7 at cycle 10 -> ignored; result Lo=15 Hi=0; single done pulse.
REQ-033 Hi=Lo=0x12345678 via MTHI/MTLO, MADDU 4*4, rst at cycle 10 of MUL -> HiLo=0, busy=0, no done; op=9 with start -> no done, no change.
